logic_unit_arbiter: RTL and testbench

- Shares one 16-bit bitwise logic unit (XOR/AND/OR/XNOR) among NREQ requesters.
- Round-robin arbitration, a valid/ready handshake per requester, one registered execute stage and a tagged response port.
- Sits between ALU front-end requesters and the shared bitwise datapath, and sequences one operation at a time.

---
 rtl/logic_unit_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_logic_unit_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: shares one bitwise logic unit (XOR/AND/OR/XNOR) among NREQ requesters.
// Latency: handshake at edge T, result registered at T+1, rsp_valid seen in the cycle after T+1.
// Backpressure: rsp_ready low holds the response in RESP; no new grants are issued until it is taken.
//
// Ports:
//   clk, rst             - rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready  - per-requester handshake; req_ready is one-hot or zero
//   req_a/req_b/req_op   - per-requester operands (WIDTH each) and 2-bit opcode, requester i at slot i
//   rsp_valid/rsp_ready  - result handshake
//   rsp_id/rsp_data      - owner of the result and the result itself, stable while rsp_valid
//   busy                 - high whenever a transaction is in flight (FSM not idle)
//
// Optional build macro LOGIC_ARB_STATS_EN adds op_count and stall_count (16-bit saturating).
// Without it neither port nor any counter logic exists.

module logic_unit_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*2-1:0]     req_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  busy
`ifdef LOGIC_ARB_STATS_EN
  ,
  output logic [15:0]           op_count,
  output logic [15:0]           stall_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  // Round-robin pointer: the requester granted most recently.
  logic [IDW-1:0]   r_last_grant;

  // Operand register, loaded only on the request handshake.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic [IDW-1:0]   r_id;

  logic             w_grant_found;
  logic [IDW-1:0]   w_grant_idx;
  int               w_idx;
  logic             w_fire;
  logic             w_rsp_fire;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [1:0]       w_sel_op;
  logic [WIDTH-1:0] w_result;

  // ------------------------------------------------------------------
  // Round-robin search starting just after the last winner.
  // The loop walks from the farthest candidate back to the nearest so
  // the last hit written is the highest-priority one; this avoids a
  // break and keeps the search a flat priority mux.
  // ------------------------------------------------------------------
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    w_idx         = 0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = (int'(r_last_grant) + k) % NREQ;
      if (req_valid[IDW'(w_idx)]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = IDW'(w_idx);
      end
    end
  end

  // Handshake only happens in IDLE; the granted bit is the only ready bit.
  assign w_fire     = (r_state == S_IDLE) && w_grant_found;
  assign w_rsp_fire = (r_state == S_RESP) && rsp_ready;

  // Ready is gated by rst so a held request cannot be acknowledged while
  // the block is being reset.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = !rst && w_fire && (w_grant_idx == IDW'(i));
    end
  end

  // Operand select for the winning requester.
  always_comb begin
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant_idx == IDW'(i)) begin
        w_sel_a  = req_a[i*WIDTH +: WIDTH];
        w_sel_b  = req_b[i*WIDTH +: WIDTH];
        w_sel_op = req_op[i*2 +: 2];
      end
    end
  end

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state and state-decoded outputs
  always_comb begin
    w_state_nxt = r_state;
    rsp_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_fire) begin
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        busy        = 1'b0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Shared bitwise unit, fed only from the operand register so input
  // changes after the handshake never reach the result.
  // ------------------------------------------------------------------
  always_comb begin
    w_result = '0;
    case (r_op)
      2'b00:   w_result = r_a ^ r_b;
      2'b01:   w_result = r_a & r_b;
      2'b10:   w_result = r_a | r_b;
      default: w_result = ~(r_a ^ r_b);
    endcase
  end

  // Operand capture, round-robin pointer and the registered execute stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_id         <= '0;
      r_last_grant <= IDW'(NREQ - 1);
      rsp_data     <= '0;
      rsp_id       <= '0;
    end else begin
      if (w_fire) begin
        r_a          <= w_sel_a;
        r_b          <= w_sel_b;
        r_op         <= w_sel_op;
        r_id         <= w_grant_idx;
        r_last_grant <= w_grant_idx;
      end
      // rsp_data/rsp_id only change leaving EXEC, so they stay put in RESP.
      if (r_state == S_EXEC) begin
        rsp_data <= w_result;
        rsp_id   <= r_id;
      end
    end
  end

`ifdef LOGIC_ARB_STATS_EN
  // Saturating counters: accepted responses and RESP cycles stalled by the consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count    <= '0;
      stall_count <= '0;
    end else begin
      if (w_rsp_fire && (op_count != 16'hFFFF)) begin
        op_count <= op_count + 16'd1;
      end
      if ((r_state == S_RESP) && !rsp_ready && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end
`else
  // Response-accept strobe only feeds the counters.
  logic w_unused;
  assign w_unused = w_rsp_fire;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
module tb_logic_unit_arbiter;

  localparam int WIDTH = 16;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic [NREQ*2-1:0]     req_op = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  busy;
`ifdef LOGIC_ARB_STATS_EN
  logic [15:0]           op_count;
  logic [15:0]           stall_count;
`endif

  int checks = 0;
  int errors = 0;

  logic_unit_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
`ifdef LOGIC_ARB_STATS_EN
    ,
    .op_count    (op_count),
    .stall_count (stall_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference for the logic unit: a per-bit truth table indexed by {a,b}.
  function automatic logic [15:0] ref_op(input logic [1:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    logic [3:0]  tt;
    logic [15:0] r;
    case (op)
      2'd0:    tt = 4'b0110;
      2'd1:    tt = 4'b1000;
      2'd2:    tt = 4'b1110;
      default: tt = 4'b1001;
    endcase
    for (int i = 0; i < 16; i++) r[i] = tt[{a[i], b[i]}];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Advance to the drive point of the next cycle (1 time unit after the edge).
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      req_b[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    end
    req_op = (NREQ*2)'($urandom);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b0;
    scramble();
    #3;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
`ifdef LOGIC_ARB_STATS_EN
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_stall_count", 32'(stall_count), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = '0;
  endtask

  // One full transaction from a lone requester, rsp_ready high. Starts and ends at an IDLE drive point.
  task automatic run_txn(input int rq, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] op, input logic [15:0] exp);
    scramble();
    req_valid                 = '0;
    req_valid[rq]             = 1'b1;
    req_a[rq*WIDTH +: WIDTH]  = a;
    req_b[rq*WIDTH +: WIDTH]  = b;
    req_op[rq*2 +: 2]         = op;
    rsp_ready                 = 1'b1;
    #3;
    chk("txn_grant", 32'(req_ready), 32'(1) << rq);
    chk("txn_busy_idle", 32'(busy), 32'd0);
    cyc();
    req_valid = '0;
    scramble();  // operands changed after the handshake must not matter
    #3;
    chk("txn_exec_valid", 32'(rsp_valid), 32'd0);
    chk("txn_exec_busy", 32'(busy), 32'd1);
    chk("txn_exec_ready", 32'(req_ready), 32'd0);
    cyc();
    #3;
    chk("txn_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("txn_rsp_data", 32'(rsp_data), 32'(exp));
    chk("txn_rsp_id", 32'(rsp_id), 32'(rq));
    cyc();
  endtask

  typedef struct {
    int         rq;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic [15:0] exp;
  } vec_t;

  initial begin
    vec_t vt[8];
    int   exp_seq[6];
    int   n_gr, n_rsp, low_run, max_low;
    logic [15:0] exp_d;
    // random-test model state
    int   m_last, m_age, m_g;
    bit   m_pend, m_found;
    logic [15:0] m_data;
    int   m_id;

    vt[0] = '{0, 16'd248,  16'd327,  2'b00, 16'h01BF};
    vt[1] = '{0, 16'd248,  16'd327,  2'b01, 16'h0040};
    vt[2] = '{0, 16'd248,  16'd327,  2'b10, 16'h01FF};
    vt[3] = '{0, 16'd248,  16'd327,  2'b11, 16'hFE40};
    vt[4] = '{1, 16'hFFFF, 16'h0000, 2'b00, 16'hFFFF};
    vt[5] = '{2, 16'hFFFF, 16'hAAAA, 2'b01, 16'hAAAA};
    vt[6] = '{3, 16'h0F0F, 16'hF0F0, 2'b11, 16'h0000};
    vt[7] = '{1, 16'h1234, 16'h0000, 2'b10, 16'h1234};
    exp_seq = '{0, 1, 2, 3, 0, 1};

    // Reset values, then the table of single transactions.
    do_reset();
    for (int i = 0; i < 8; i++) run_txn(vt[i].rq, vt[i].a, vt[i].b, vt[i].op, vt[i].exp);

    // All four requesting continuously: rotating grants, one-cycle idle gaps.
    do_reset();
    scramble();
    req_valid = '1;
    rsp_ready = 1'b1;
    n_gr = 0; n_rsp = 0; low_run = 0; max_low = 0;
    for (int c = 0; c < 40 && n_rsp < 6; c++) begin
      #3;
      if (req_ready != '0) begin
        if (n_gr < 6) chk("rr_grant", 32'(req_ready), 32'(1) << exp_seq[n_gr]);
        n_gr++;
      end
      if (rsp_valid) begin
        if (n_rsp < 6) chk("rr_rsp_id", 32'(rsp_id), 32'(exp_seq[n_rsp]));
        n_rsp++;
      end
      if (!busy) begin
        low_run++;
        if (low_run > max_low) max_low = low_run;
      end else begin
        low_run = 0;
      end
      cyc();
    end
    chk("rr_rsp_count", 32'(n_rsp), 32'd6);
    chk("rr_busy_gap", 32'(max_low), 32'd1);
    req_valid = '0;

    // Response held off for 5 cycles while requester 2 waits.
    do_reset();
    scramble();
    req_valid          = 4'b0101;
    req_a[0 +: WIDTH]  = 16'h1234;
    req_b[0 +: WIDTH]  = 16'h00FF;
    req_op[0 +: 2]     = 2'b00;
    exp_d              = ref_op(2'b00, 16'h1234, 16'h00FF);
    rsp_ready          = 1'b0;
    #3;
    chk("stall_grant0", 32'(req_ready), 32'd1);
    cyc();
    req_a[0 +: WIDTH] = 16'hDEAD;
    #3;
    chk("stall_exec_ready", 32'(req_ready), 32'd0);
    cyc();
    for (int c = 0; c < 5; c++) begin
      #3;
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_data", 32'(rsp_data), 32'(exp_d));
      chk("stall_id", 32'(rsp_id), 32'd0);
      chk("stall_ready", 32'(req_ready), 32'd0);
      cyc();
    end
    rsp_ready = 1'b1;
    #3;
    chk("stall_accept_valid", 32'(rsp_valid), 32'd1);
    cyc();
    #3;
    chk("stall_regrant2", 32'(req_ready), 32'b0100);
    cyc();
    req_valid = '0;

    // Reset during EXEC of requester 1: transaction dropped, pointer restarts at 0.
    do_reset();
    run_txn(3, 16'hFFFF, 16'h0000, 2'b00, 16'hFFFF);
    req_valid = 4'b0010;
    #3;
    chk("rexec_grant1", 32'(req_ready), 32'b0010);
    cyc();
    req_valid = '0;
    #1;
    rst = 1'b1;
    #1;
    chk("rexec_busy", 32'(busy), 32'd0);
    chk("rexec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rexec_rsp_data", 32'(rsp_data), 32'd0);
    chk("rexec_rsp_id", 32'(rsp_id), 32'd0);
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #3;
      chk("rexec_no_rsp", 32'(rsp_valid), 32'd0);
      cyc();
    end
    req_valid = '1;
    #3;
    chk("rexec_next_grant0", 32'(req_ready), 32'b0001);
    cyc();
    req_valid = '0;

`ifdef LOGIC_ARB_STATS_EN
    // Three transactions, one stalled for 4 cycles.
    do_reset();
    run_txn(0, 16'h00F0, 16'h0FF0, 2'b01, 16'h00F0);
    run_txn(2, 16'h00F0, 16'h0FF0, 2'b10, 16'h0FF0);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    cyc();
    req_valid = '0;
    cyc();
    for (int c = 0; c < 4; c++) cyc();
    rsp_ready = 1'b1;
    cyc();
    #3;
    chk("stats_op_count", 32'(op_count), 32'd3);
    chk("stats_stall_count", 32'(stall_count), 32'd4);
    cyc();
`endif

    // Randomized traffic against a transaction-level model.
    do_reset();
    m_last = NREQ - 1;
    m_pend = 1'b0;
    m_age  = 0;
    m_data = '0;
    m_id   = 0;
    for (int c = 0; c < 3000; c++) begin
      scramble();
      req_valid = NREQ'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      m_found = 1'b0;
      m_g     = 0;
      if (!m_pend) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (!m_found && req_valid[(m_last + k) % NREQ]) begin
            m_found = 1'b1;
            m_g     = (m_last + k) % NREQ;
          end
        end
      end
      #3;
      chk("rnd_req_ready", 32'(req_ready), m_found ? (32'(1) << m_g) : 32'd0);
      chk("rnd_rsp_valid", 32'(rsp_valid), 32'(m_pend && m_age >= 1));
      chk("rnd_busy", 32'(busy), 32'(m_pend));
      if (m_pend && m_age >= 1) begin
        chk("rnd_rsp_data", 32'(rsp_data), 32'(m_data));
        chk("rnd_rsp_id", 32'(rsp_id), 32'(m_id));
      end
      if (m_found) begin
        m_pend = 1'b1;
        m_age  = 0;
        m_data = ref_op(req_op[m_g*2 +: 2], req_a[m_g*WIDTH +: WIDTH], req_b[m_g*WIDTH +: WIDTH]);
        m_id   = m_g;
        m_last = m_g;
      end else if (m_pend) begin
        if (m_age >= 1 && rsp_ready) m_pend = 1'b0;
        else m_age++;
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
